debounce_fsm: RTL and testbench



---
 rtl/debounce_fsm.sv | 139 +++++++++++++
 tb/tb_debounce_fsm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/debounce_fsm.sv
// Debounces a raw level: db_out follows the sampled input only after STABLE_CYCLES identical samples.
// Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop synchronizer ahead of the FSM.
module debounce_fsm #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic db_out,
  output logic busy,
  output logic glitch
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  localparam state_t RESET_STATE = RESET_LEVEL ? IDLE_HIGH : IDLE_LOW;

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= RESET_LEVEL;
      sync_q2 <= RESET_LEVEL;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = raw_in;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          db_nxt, busy_nxt, glitch_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RESET_STATE;
      cnt    <= '0;
      db_out <= RESET_LEVEL;
      busy   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      db_out <= db_nxt;
      busy   <= busy_nxt;
      glitch <= glitch_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    db_nxt     = db_out;
    busy_nxt   = busy;
    glitch_nxt = 1'b0;
    case (state)
      IDLE_LOW: begin
        db_nxt   = 1'b0;
        busy_nxt = 1'b0;
        cnt_nxt  = '0;
        if (s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CW'(1);
          busy_nxt  = 1'b1;
        end
      end
      WAIT_HIGH: begin
        db_nxt = 1'b0;
        if (!s) begin
          state_nxt  = IDLE_LOW;
          cnt_nxt    = '0;
          busy_nxt   = 1'b0;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
          db_nxt    = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt  = cnt + CW'(1);
          busy_nxt = 1'b1;
        end
      end
      IDLE_HIGH: begin
        db_nxt   = 1'b1;
        busy_nxt = 1'b0;
        cnt_nxt  = '0;
        if (!s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CW'(1);
          busy_nxt  = 1'b1;
        end
      end
      WAIT_LOW: begin
        db_nxt = 1'b1;
        if (s) begin
          state_nxt  = IDLE_HIGH;
          cnt_nxt    = '0;
          busy_nxt   = 1'b0;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
          db_nxt    = 1'b0;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt  = cnt + CW'(1);
          busy_nxt = 1'b1;
        end
      end
      default: begin
        // Any corrupted encoding falls back to the reset idle state.
        state_nxt = RESET_STATE;
        cnt_nxt   = '0;
        db_nxt    = RESET_LEVEL;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm: directed scenarios then random runs, checked against a run-length model.
module tb_debounce_fsm;

  localparam int unsigned SC = 4;
  localparam bit          RL = 1'b0;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic raw_in = 1'b0;
  logic db_out, busy, glitch;

  int errors = 0;
  int checks = 0;

  // Reference model: current level plus length of the run of samples that disagree with it.
  logic m_db = RL;
  logic m_busy = 1'b0;
  logic m_glitch = 1'b0;
  int   m_run = 0;
  logic m_s1 = RL;
  logic m_s2 = RL;

  debounce_fsm #(.STABLE_CYCLES(SC), .RESET_LEVEL(RL)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .db_out(db_out), .busy(busy), .glitch(glitch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".db_out"}, db_out, m_db);
    check({tag, ".busy"}, busy, m_busy);
    check({tag, ".glitch"}, glitch, m_glitch);
  endtask

  task automatic model_reset();
    m_db = RL; m_busy = 1'b0; m_glitch = 1'b0; m_run = 0;
    m_s1 = RL; m_s2 = RL;
  endtask

  task automatic model_edge(input logic v);
    logic s;
    if (LAT == 2) begin
      s = m_s2; m_s2 = m_s1; m_s1 = v;
    end else begin
      s = v;
    end
    m_glitch = 1'b0;
    if (s != m_db) begin
      m_run++;
      if (m_run == SC) begin
        m_db = s;
        m_run = 0;
      end
    end else if (m_run > 0) begin
      m_glitch = 1'b1;
      m_run = 0;
    end
    m_busy = (m_run > 0);
  endtask

  task automatic step(input logic v, input string tag);
    raw_in = v;
    @(posedge clk);
    if (reset) model_edge(v);
    #1;
    check_all(tag);
  endtask

  task automatic run(input logic v, input int n, input string tag);
    for (int i = 0; i < n; i++) step(v, tag);
  endtask

  int glitch_seen;

  initial begin
    // Reset held across two edges with raw_in high.
    #1;
    check_all("rst0");
    run(1'b1, 2, "rst_hold");
    reset = 1'b1;
    run(1'b1, SC + LAT, "rise");
    check("rise.final_db", db_out, 1'b1);

    // Held low from a high level: clean fall, no pulse.
    glitch_seen = 0;
    for (int i = 0; i < SC + LAT; i++) begin
      step(1'b0, "fall");
      if (glitch) glitch_seen++;
    end
    check("fall.final_db", db_out, 1'b0);
    check("fall.no_glitch", glitch_seen != 0, 1'b0);

    // Short high burst then low: exactly one glitch pulse.
    run(1'b1, 2, "burst");
    glitch_seen = 0;
    for (int i = 0; i < 3 + LAT; i++) begin
      step(1'b0, "abort");
      if (glitch) glitch_seen++;
    end
    check("abort.one_pulse", glitch_seen == 1, 1'b1);
    check("abort.db", db_out, 1'b0);

    // 3 high, 1 low, 4 high.
    run(1'b1, 3, "r4a");
    step(1'b0, "r4b");
    run(1'b1, 3, "r4c");
    check("r4.db_before", db_out, 1'b0);
    step(1'b1, "r4d");
    run(1'b1, LAT + 1, "r4e");
    check("r4.db_after", db_out, 1'b1);

    // Reset mid-qualification, asynchronously.
    run(1'b0, SC + LAT + 2, "r5low");
    run(1'b1, 2 + LAT, "r5pre");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("r5async");
    run(1'b1, 2, "r5hold");
    #2;
    reset = 1'b1;
    run(1'b1, SC + LAT - 1, "r5post");
    check("r5.db_not_yet", db_out, 1'b0);
    step(1'b1, "r5last");
    check("r5.db_set", db_out, 1'b1);

    // Random runs of varying lengths around the threshold.
    for (int r = 0; r < 60; r++) begin
      logic v;
      int n;
      v = 1'($urandom_range(0, 1));
      n = $urandom_range(1, SC + LAT + 2);
      run(v, n, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
